// File: rtl/riscv_boot_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_boot_ctrl
//
// Boot / in-system-programming sequencer for the RISC-V core. Sits between the
// UART programmer (uart_bmpg_0) and the ifetch / riscv_io_bridge programming
// ports. A debounced press of start_pg releases the programmer from reset and
// holds the core in reset. Programmer writes are forwarded to instruction
// memory (adr[14]=0) or data memory (adr[14]=1). After the programmer reports
// done, the core stays in reset for RELEASE_DELAY cycles before running again.
//
// Optional build macro: BOOT_CTRL_TIMEOUT_EN
//   When defined, a session that has accepted at least one write and then sees
//   TIMEOUT_CYCLES consecutive idle cycles is ended as if upg_done_i had been
//   seen, and err_o is set.
//
// Ports:
//   clk          system clock, all logic on posedge
//   rst          synchronous active-high reset
//   start_pg     raw programming button
//   upg_wen_i    programmer write strobe
//   upg_adr_i    programmer word address, bit 14 selects dmem(1)/imem(0)
//   upg_dat_i    programmer write data
//   upg_done_i   programmer finished
//   upg_rst_o    programmer reset (1 = held in reset)
//   cpu_rst_o    core reset (combinational: rst or programming in progress)
//   imem_wen_o   instruction memory write pulse
//   dmem_wen_o   data memory write pulse
//   mem_adr_o    programming word address
//   mem_dat_o    programming write data
//   prog_busy_o  high in ARM, PROG or RELEASE
//   word_cnt_o   writes accepted in the current/last session (saturating)
//   err_o        sticky protocol error
// -----------------------------------------------------------------------------
module riscv_boot_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RELEASE_DELAY   = 8,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_pg,
  input  logic        upg_wen_i,
  input  logic [14:0] upg_adr_i,
  input  logic [31:0] upg_dat_i,
  input  logic        upg_done_i,
  output logic        upg_rst_o,
  output logic        cpu_rst_o,
  output logic        imem_wen_o,
  output logic        dmem_wen_o,
  output logic [13:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  output logic        prog_busy_o,
  output logic [15:0] word_cnt_o,
  output logic        err_o
);

  if (DEBOUNCE_CYCLES < 1 || RELEASE_DELAY < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("riscv_boot_ctrl: DEBOUNCE_CYCLES, RELEASE_DELAY and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_RUN,
    ST_ARM,
    ST_PROG,
    ST_RELEASE
  } state_t;

  localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int REL_W = $clog2(RELEASE_DELAY + 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [REL_W-1:0] REL_LAST = REL_W'(RELEASE_DELAY - 1);

  state_t             state;
  logic               start_prev;
  logic [DEB_W-1:0]   deb_cnt;
  logic [DEB_W-1:0]   deb_inc;
  logic [REL_W-1:0]   rel_cnt;
  logic               timeout;

  // The edge cycle in RUN is the first high cycle, so PROG is entered on the
  // DEBOUNCE_CYCLES-th consecutive high cycle.
  assign deb_inc = deb_cnt + 1'b1;

`ifdef BOOT_CTRL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

  logic [IDLE_W-1:0] idle_cnt;

  // Idle time only counts once the session has accepted a write, so a slow
  // programmer start-up is never mistaken for a stalled session.
  always_ff @(posedge clk) begin
    if (rst || state != ST_PROG || upg_wen_i) begin
      idle_cnt <= '0;
    end else if (word_cnt_o != 16'd0) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign timeout = (state == ST_PROG) && !upg_wen_i &&
                   (word_cnt_o != 16'd0) && (idle_cnt == IDLE_LAST);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block samples the values from before the clock edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RUN;
      start_prev <= 1'b1;   // a button held through reset must not arm
      deb_cnt    <= '0;
      rel_cnt    <= '0;
      upg_rst_o  <= 1'b1;
      imem_wen_o <= 1'b0;
      dmem_wen_o <= 1'b0;
      mem_adr_o  <= '0;
      mem_dat_o  <= '0;
      word_cnt_o <= '0;
      err_o      <= 1'b0;
    end else begin
      start_prev <= start_pg;
      imem_wen_o <= 1'b0;
      dmem_wen_o <= 1'b0;

      case (state)
        ST_RUN: begin
          if (start_pg && !start_prev) begin
            state   <= ST_ARM;
            deb_cnt <= '0;
          end
        end

        ST_ARM: begin
          if (!start_pg) begin
            state <= ST_RUN;
          end else if (deb_inc >= DEB_LAST) begin
            state      <= ST_PROG;
            upg_rst_o  <= 1'b0;
            word_cnt_o <= '0;
            err_o      <= 1'b0;
          end else begin
            deb_cnt <= deb_inc;
          end
        end

        ST_PROG: begin
          if (upg_wen_i) begin
            imem_wen_o <= ~upg_adr_i[14];
            dmem_wen_o <=  upg_adr_i[14];
            mem_adr_o  <=  upg_adr_i[13:0];
            mem_dat_o  <=  upg_dat_i;
            if (word_cnt_o != 16'hFFFF) begin
              word_cnt_o <= word_cnt_o + 16'd1;
            end
          end
          if (upg_done_i || timeout) begin
            state   <= ST_RELEASE;
            rel_cnt <= '0;
            // done with nothing ever written is a protocol error
            if (timeout || (word_cnt_o == 16'd0 && !upg_wen_i)) begin
              err_o <= 1'b1;
            end
          end
        end

        ST_RELEASE: begin
          if (upg_wen_i) begin
            err_o <= 1'b1;        // late write, dropped
          end
          if (rel_cnt == REL_LAST) begin
            state     <= ST_RUN;
            upg_rst_o <= 1'b1;
          end else begin
            rel_cnt <= rel_cnt + 1'b1;
          end
        end

        default: begin
          state     <= ST_RUN;
          upg_rst_o <= 1'b1;
        end
      endcase
    end
  end

  // NOTE: cpu_rst_o is deliberately combinational so the core sees rst in the
  // same cycle it is asserted; it is a continuous assign, so no latch risk.
  assign cpu_rst_o   = rst || (state == ST_PROG) || (state == ST_RELEASE);
  assign prog_busy_o = (state != ST_RUN);

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// -----------------------------------------------------------------------------
// tb_riscv_boot_ctrl
//
// Self-checking bench for riscv_boot_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point, i.e. after the edge that
// produced them. Each forwarded programmer write is pushed to a queue when it
// is driven and popped by a monitor when a memory write pulse appears.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_riscv_boot_ctrl;

  localparam int DEB = 16;
  localparam int REL = 8;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_pg;
  logic        upg_wen_i;
  logic [14:0] upg_adr_i;
  logic [31:0] upg_dat_i;
  logic        upg_done_i;
  logic        upg_rst_o;
  logic        cpu_rst_o;
  logic        imem_wen_o;
  logic        dmem_wen_o;
  logic [13:0] mem_adr_o;
  logic [31:0] mem_dat_o;
  logic        prog_busy_o;
  logic [15:0] word_cnt_o;
  logic        err_o;

  riscv_boot_ctrl #(
    .DEBOUNCE_CYCLES (DEB),
    .RELEASE_DELAY   (REL),
    .TIMEOUT_CYCLES  (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_pg    (start_pg),
    .upg_wen_i   (upg_wen_i),
    .upg_adr_i   (upg_adr_i),
    .upg_dat_i   (upg_dat_i),
    .upg_done_i  (upg_done_i),
    .upg_rst_o   (upg_rst_o),
    .cpu_rst_o   (cpu_rst_o),
    .imem_wen_o  (imem_wen_o),
    .dmem_wen_o  (dmem_wen_o),
    .mem_adr_o   (mem_adr_o),
    .mem_dat_o   (mem_dat_o),
    .prog_busy_o (prog_busy_o),
    .word_cnt_o  (word_cnt_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // {imem_wen, dmem_wen, adr[13:0], dat[31:0]}
  logic [47:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write-pulse monitor: every pulse must match the oldest expected write.
  always @(posedge clk) begin
    #1;
    if (imem_wen_o || dmem_wen_o) begin
      check("unexpected_wen", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("fwd_write", {imem_wen_o, dmem_wen_o, mem_adr_o, mem_dat_o}, exp_q.pop_front());
      end
    end
  end

  task automatic prog_write(input logic [14:0] adr, input logic [31:0] dat, input logic done);
    upg_wen_i  = 1'b1;
    upg_adr_i  = adr;
    upg_dat_i  = dat;
    upg_done_i = done;
    exp_q.push_back({~adr[14], adr[14], adr[13:0], dat});
    tick();
    upg_wen_i  = 1'b0;
    upg_done_i = 1'b0;
  endtask

  // Clean rising edge, then exactly DEB high cycles; checks the boundary.
  task automatic enter_prog(input string tag);
    start_pg = 1'b0;
    tick();
    start_pg = 1'b1;
    repeat (DEB - 1) tick();
    check({tag, "_not_yet"}, {cpu_rst_o, prog_busy_o}, 2'b01);
    tick();
    start_pg = 1'b0;
    check({tag, "_prog"}, {cpu_rst_o, upg_rst_o, prog_busy_o}, 3'b101);
  endtask

  initial begin
    rst        = 1'b1;
    start_pg   = 1'b1;
    upg_wen_i  = 1'b0;
    upg_adr_i  = '0;
    upg_dat_i  = '0;
    upg_done_i = 1'b0;
    #1;
    repeat (3) tick();
    check("cpu_rst_in_rst", cpu_rst_o, 1'b1);
    rst = 1'b0;
    #1;
    check("reset_state", {upg_rst_o, cpu_rst_o, prog_busy_o, imem_wen_o, dmem_wen_o, err_o}, 6'b100000);
    check("reset_regs", {word_cnt_o, mem_adr_o, mem_dat_o}, 64'd0);

    // Button held through reset must not arm.
    repeat (20) tick();
    check("held_no_arm", {prog_busy_o, cpu_rst_o}, 2'b00);
    start_pg = 1'b0;
    tick();

    // 1: short press -> ARM then back to RUN.
    start_pg = 1'b1;
    tick();
    check("short_arm", {prog_busy_o, cpu_rst_o, upg_rst_o}, 3'b101);
    repeat (4) tick();
    start_pg = 1'b0;
    tick();
    check("short_run", {prog_busy_o, cpu_rst_o, upg_rst_o}, 3'b001);

    // 2: full debounce -> PROG; start_pg is ignored afterwards.
    enter_prog("deb1");
    tick();
    check("prog_stays", cpu_rst_o, 1'b1);

    // 3: imem and dmem writes.
    prog_write(15'h0004, 32'h00500093, 1'b0);
    tick();
    prog_write(15'h4010, 32'hDEADBEEF, 1'b0);
    check("word_cnt_2", word_cnt_o, 16'd2);

    // 4: final write concurrent with done, then release delay.
    prog_write(15'h0123, 32'h12345678, 1'b1);
    check("word_cnt_3", word_cnt_o, 16'd3);
    for (int i = 0; i < REL; i++) begin
      check("release_hold", {cpu_rst_o, upg_rst_o, prog_busy_o}, 3'b101);
      tick();
    end
    check("release_done", {cpu_rst_o, upg_rst_o, prog_busy_o, err_o}, 4'b0100);

    // 5a: done with no writes -> err, still proceeds to RUN; err is sticky.
    enter_prog("deb2");
    check("word_cnt_clr", word_cnt_o, 16'd0);
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    check("empty_done_err", {err_o, cpu_rst_o}, 2'b11);
    repeat (REL) tick();
    check("empty_done_run", {err_o, cpu_rst_o, upg_rst_o}, 3'b101);

    // 5b: err clears on PROG entry; boundary addresses; write in RELEASE.
    enter_prog("deb3");
    check("err_clr_entry", err_o, 1'b0);
    prog_write(15'h3FFF, 32'hAAAA5555, 1'b0);
    prog_write(15'h7FFF, 32'h0000FFFF, 1'b1);
    check("no_err_done", {err_o, word_cnt_o}, {1'b0, 16'd2});
    upg_wen_i = 1'b1;
    upg_adr_i = 15'h4001;
    upg_dat_i = 32'hBADBAD00;
    tick();
    upg_wen_i = 1'b0;
    check("release_wen_err", {err_o, imem_wen_o, dmem_wen_o}, 3'b100);
    repeat (REL - 1) tick();
    check("release_wen_run", {cpu_rst_o, upg_rst_o, err_o}, 3'b011);

    // 6: reset mid-PROG coinciding with a write -> write discarded.
    enter_prog("deb4");
    prog_write(15'h0042, 32'h0BADF00D, 1'b0);
    upg_wen_i = 1'b1;
    upg_adr_i = 15'h0043;
    upg_dat_i = 32'h11111111;
    rst       = 1'b1;
    tick();
    rst       = 1'b0;
    upg_wen_i = 1'b0;
    #1;
    check("rst_mid_prog", {cpu_rst_o, upg_rst_o, prog_busy_o, imem_wen_o, dmem_wen_o, err_o}, 6'b010000);
    check("rst_word_cnt", word_cnt_o, 16'd0);
    tick();

`ifdef BOOT_CTRL_TIMEOUT_EN
    // Idle timeout after one write.
    enter_prog("deb5");
    prog_write(15'h0001, 32'hCAFEF00D, 1'b0);
    repeat (TMO - 1) tick();
    check("tmo_not_yet", {cpu_rst_o, err_o}, 2'b10);
    tick();
    check("tmo_release", {cpu_rst_o, err_o}, 2'b11);
    repeat (REL) tick();
    check("tmo_run", {cpu_rst_o, upg_rst_o}, 2'b01);
`else
    // Without the timeout, PROG waits indefinitely for done.
    enter_prog("deb5");
    prog_write(15'h0001, 32'hCAFEF00D, 1'b0);
    repeat (3 * TMO) tick();
    check("no_tmo", {cpu_rst_o, err_o}, 2'b10);
    upg_done_i = 1'b1;
    tick();
    upg_done_i = 1'b0;
    repeat (REL) tick();
    check("no_tmo_run", {cpu_rst_o, upg_rst_o, err_o}, 3'b010);
`endif

    tick();
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
